// File: rtl/interleaver_arb.sv
// interleaver_arb
//   Round-robin arbiter that lets one of two serial-bit requesters own a
//   complete interleaver frame. The winner streams FRAME_BITS bits into the
//   interleaver. The block then waits for FRAME_NIBBLES output-valid pulses,
//   or gives up after DRAIN_TIMEOUT cycles. One guard cycle follows, and the
//   block then returns to idle.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   s0_valid, s0_bit     requester 0 serial bit and its valid
//   s1_valid, s1_bit     requester 1 serial bit and its valid
//   s0_ready, s1_ready   bit accepted when valid && ready
//   ilv_load_en          interleaver load strobe (one cycle after acceptance)
//   ilv_in_bit           interleaver input bit (holds when not loading)
//   ilv_data_valid       interleaver output-valid pulse (counted in DRAIN only)
//   grant[1:0]           one-hot owner of the current frame
//   busy                 high whenever not idle
//   frame_done           one-cycle pulse after a normal drain
//   drain_err            one-cycle pulse after a drain timeout
//   frame_cnt[15:0]      completed frames (wrapping)
//   err_cnt[7:0]         drain timeouts (saturating)
//
// Build option
//   INTERLEAVER_ARB_STATS_EN: when defined, frame_cnt and err_cnt count.
//   When undefined, both outputs are tied to zero and have no registers.
module interleaver_arb #(
    parameter int FRAME_BITS    = 128,
    parameter int FRAME_NIBBLES = 32,
    parameter int DRAIN_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    input  logic        s0_bit,
    input  logic        s1_valid,
    input  logic        s1_bit,
    output logic        s0_ready,
    output logic        s1_ready,
    output logic        ilv_load_en,
    output logic        ilv_in_bit,
    input  logic        ilv_data_valid,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        frame_done,
    output logic        drain_err,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, GUARD} state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  grant_nx;
    logic        done_nx;
    logic        err_nx;
    logic        rr_s1;      // s1 wins a tie when set (s0 was served last)
    logic [6:0]  bit_cnt;
    logic [5:0]  nib_cnt;
    logic [5:0]  cyc_cnt;
    logic        accept;
    logic        acc_bit;
    logic        last_bit;
    logic        nib_hit;
    logic        timeout;

    assign s0_ready = grant[0] && (state == LOAD);
    assign s1_ready = grant[1] && (state == LOAD);
    assign busy     = (state != IDLE);

    assign accept   = (s0_ready && s0_valid) || (s1_ready && s1_valid);
    assign acc_bit  = grant[1] ? s1_bit : s0_bit;
    assign last_bit = (bit_cnt == 7'(FRAME_BITS - 1));
    assign nib_hit  = ilv_data_valid && (nib_cnt == 6'(FRAME_NIBBLES - 1));
    assign timeout  = (cyc_cnt == 6'(DRAIN_TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    state_nx = LOAD;
                    if (s0_valid && (!s1_valid || !rr_s1)) grant_nx = 2'b01;
                    else                                   grant_nx = 2'b10;
                end
            end
            LOAD: begin
                if (accept && last_bit) state_nx = DRAIN;
            end
            DRAIN: begin
                // A completed count wins over a coincident timeout.
                if (nib_hit) begin
                    done_nx  = 1'b1;
                    state_nx = GUARD;
                end else if (timeout) begin
                    err_nx   = 1'b1;
                    state_nx = GUARD;
                end
            end
            GUARD: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            rr_s1       <= 1'b0;
            bit_cnt     <= '0;
            nib_cnt     <= '0;
            cyc_cnt     <= '0;
            ilv_load_en <= 1'b0;
            ilv_in_bit  <= 1'b0;
            frame_done  <= 1'b0;
            drain_err   <= 1'b0;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            if (state == IDLE && state_nx == LOAD) rr_s1 <= grant_nx[0];

            if (state == IDLE)  bit_cnt <= '0;
            else if (accept)    bit_cnt <= bit_cnt + 7'd1;

            if (state != DRAIN) begin
                nib_cnt <= '0;
                cyc_cnt <= '0;
            end else begin
                nib_cnt <= nib_cnt + 6'(ilv_data_valid);
                cyc_cnt <= cyc_cnt + 6'd1;
            end

            ilv_load_en <= accept;
            if (accept) ilv_in_bit <= acc_bit;

            frame_done <= done_nx;
            drain_err  <= err_nx;
        end
    end

`ifdef INTERLEAVER_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (done_nx) frame_cnt <= frame_cnt + 16'd1;
            if (err_nx && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_interleaver_arb.sv
// tb_interleaver_arb
//   Self-checking bench for interleaver_arb. Random payload bits and random
//   drain-pulse placement. Expectations come from a frame-level model:
//   round-robin owner choice, the accepted bit stream, and the drain outcome
//   derived from the pulse pattern.
module tb_interleaver_arb;

    localparam int FRAME_BITS    = 128;
    localparam int FRAME_NIBBLES = 32;
    localparam int DRAIN_TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s0_bit, s1_valid, s1_bit;
    logic        s0_ready, s1_ready;
    logic        ilv_load_en, ilv_in_bit, ilv_data_valid;
    logic [1:0]  grant;
    logic        busy, frame_done, drain_err;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    // frame-level model state
    int last_owner;
    bit last_loaded;
    int frames_ok;
    int errs_seen;

    always #5 clk = ~clk;

    interleaver_arb #(
        .FRAME_BITS   (FRAME_BITS),
        .FRAME_NIBBLES(FRAME_NIBBLES),
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s0_valid      (s0_valid),
        .s0_bit        (s0_bit),
        .s1_valid      (s1_valid),
        .s1_bit        (s1_bit),
        .s0_ready      (s0_ready),
        .s1_ready      (s1_ready),
        .ilv_load_en   (ilv_load_en),
        .ilv_in_bit    (ilv_in_bit),
        .ilv_data_valid(ilv_data_valid),
        .grant         (grant),
        .busy          (busy),
        .frame_done    (frame_done),
        .drain_err     (drain_err),
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt)
    );

    task automatic model_reset();
        last_owner  = 1;   // s0 favoured after reset
        last_loaded = 1'b0;
        frames_ok   = 0;
        errs_seen   = 0;
    endtask

    function automatic int pick_owner(input bit r0, input bit r1);
        if (r0 && r1) return (last_owner == 0) ? 1 : 0;
        return r0 ? 0 : 1;
    endfunction

    // Pulse patterns indexed by DRAIN cycle number (cycle 1 always empty).
    function automatic bit [47:0] pat_normal();
        bit [47:0] p = '0;
        int n = 0;
        for (int k = 2; k <= DRAIN_TIMEOUT; k++) begin
            p[k] = 1'b1;
            n++;
        end
        while (n > FRAME_NIBBLES) begin
            int k;
            k = int'($urandom_range(2, DRAIN_TIMEOUT));
            if (p[k]) begin
                p[k] = 1'b0;
                n--;
            end
        end
        return p;
    endfunction

    function automatic bit [47:0] pat_short(input int cnt);
        bit [47:0] p = '0;
        int n = 0;
        while (n < cnt) begin
            int k;
            k = int'($urandom_range(2, DRAIN_TIMEOUT));
            if (!p[k]) begin
                p[k] = 1'b1;
                n++;
            end
        end
        return p;
    endfunction

    function automatic bit [47:0] pat_edge();
        bit [47:0] p = '0;
        for (int k = DRAIN_TIMEOUT - FRAME_NIBBLES + 1; k <= DRAIN_TIMEOUT; k++) p[k] = 1'b1;
        return p;
    endfunction

    // Streams one frame. gap_at >= 0 drops the owner's valid for gap_len cycles
    // after gap_at accepted bits; abort_at > 0 asserts rst after that many bits.
    task automatic run_frame(input bit r0, input bit r1, input int gap_at,
                             input int gap_len, input int abort_at);
        int own;
        logic [1:0] exp_grant;
        int acc = 0, loads = 0, iter = 0, gap_left = 0;
        bit gap_done = 1'b0, prev_acc = 1'b0, prev_bit = 1'b0;
        bit b0, b1, v0, v1, a, exp_bit;
        own        = pick_owner(r0, r1);
        last_owner = own;
        exp_grant  = (own == 0) ? 2'b01 : 2'b10;
        b0 = 1'($urandom);
        b1 = 1'($urandom);
        while (acc < FRAME_BITS && iter < 1000) begin
            iter++;
            @(posedge clk); #1;
            if (abort_at > 0 && acc == abort_at) begin
                #2 rst = 1'b1;
                #1;
                checks++;
                if ({grant, s0_ready, s1_ready, ilv_load_en, ilv_in_bit, busy,
                     frame_done, drain_err, frame_cnt, err_cnt} !== 33'd0) begin
                    errors++;
                    $display("FAIL reset_mid_frame: got grant=%b rdy=%b%b load=%b bit=%b busy=%b done=%b err=%b fcnt=%0d ecnt=%0d, required all 0",
                             grant, s0_ready, s1_ready, ilv_load_en, ilv_in_bit, busy,
                             frame_done, drain_err, frame_cnt, err_cnt);
                end
                s0_valid = 1'b0;
                s1_valid = 1'b0;
                @(negedge clk);
                @(posedge clk); #1;
                rst = 1'b0;
                model_reset();
                return;
            end
            if (gap_at >= 0 && acc == gap_at && !gap_done) begin
                gap_left = gap_len;
                gap_done = 1'b1;
            end
            v0 = r0 && !(own == 0 && gap_left > 0);
            v1 = r1 && !(own == 1 && gap_left > 0);
            s0_valid = v0; s0_bit = b0;
            s1_valid = v1; s1_bit = b1;
            ilv_data_valid = 1'($urandom);
            @(negedge clk);
            exp_bit = prev_acc ? prev_bit : last_loaded;
            checks++;
            if (ilv_load_en !== prev_acc || ilv_in_bit !== exp_bit) begin
                errors++;
                $display("FAIL load_latency: got load_en=%b bit=%b, required load_en=%b bit=%b (accepted=%0d)",
                         ilv_load_en, ilv_in_bit, prev_acc, exp_bit, acc);
            end
            if (prev_acc) begin
                last_loaded = prev_bit;
                loads++;
            end
            checks++;
            if ((own == 0 && s1_ready !== 1'b0) || (own == 1 && s0_ready !== 1'b0)) begin
                errors++;
                $display("FAIL nonowner_ready: got s0_ready=%b s1_ready=%b, required 0 for non-owner (owner s%0d)",
                         s0_ready, s1_ready, own);
            end
            checks++;
            if ((busy && grant !== exp_grant) || (!busy && grant !== 2'b00)) begin
                errors++;
                $display("FAIL grant: got %b (busy=%b), required %b while busy else 00",
                         grant, busy, exp_grant);
            end
            if (gap_left > 0) begin
                checks++;
                if ((own == 0 ? s0_ready : s1_ready) !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_ready: got 0, required 1 during valid gap");
                end
                gap_left--;
            end
            a = (own == 0) ? (v0 && s0_ready) : (v1 && s1_ready);
            prev_acc = a;
            prev_bit = (own == 0) ? b0 : b1;
            if (a) begin
                acc++;
                if (own == 0) b0 = 1'($urandom);
                else          b1 = 1'($urandom);
            end
        end
        if (acc < FRAME_BITS) begin
            checks++;
            errors++;
            $display("FAIL load_budget: got %0d accepted bits, required %0d", acc, FRAME_BITS);
            return;
        end
        // Valid stays high here: a 129th bit must not be taken.
        @(posedge clk); #1;
        s0_valid = r0; s0_bit = b0;
        s1_valid = r1; s1_bit = b1;
        ilv_data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ilv_load_en !== 1'b1 || ilv_in_bit !== prev_bit) begin
            errors++;
            $display("FAIL last_load: got load_en=%b bit=%b, required 1 %b", ilv_load_en, ilv_in_bit, prev_bit);
        end
        last_loaded = prev_bit;
        loads++;
        checks++;
        if (s0_ready !== 1'b0 || s1_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_last: got rdy=%b%b busy=%b, required 00 1", s0_ready, s1_ready, busy);
        end
        checks++;
        if (loads != FRAME_BITS) begin
            errors++;
            $display("FAIL load_count: got %0d, required %0d", loads, FRAME_BITS);
        end
    endtask

    // Drives the drain pulse pattern and checks the outcome, pulse timing,
    // the single guard cycle, and the statistics outputs.
    task automatic run_drain(input bit [47:0] pat, input bit keep_req);
        int cnt = 0, exit_k = DRAIN_TIMEOUT;
        bit ok = 1'b0, rdy_seen = 1'b0;
        int done_n = 0, err_n = 0, done_at = 0, err_at = 0, idle_at = 0;
        logic [1:0] idle_grant = 2'bxx;
        logic [15:0] exp_fcnt;
        logic [7:0]  exp_ecnt;
        for (int k = 1; k <= DRAIN_TIMEOUT; k++) begin
            if (!ok && pat[k]) begin
                cnt++;
                if (cnt == FRAME_NIBBLES) begin
                    ok = 1'b1;
                    exit_k = k;
                end
            end
        end
        for (int k = 2; k < 48 && idle_at == 0; k++) begin
            @(posedge clk); #1;
            ilv_data_valid = pat[k];
            if (!keep_req) begin
                s0_valid = 1'b0;
                s1_valid = 1'b0;
            end
            @(negedge clk);
            if (frame_done) begin done_n++; done_at = k; end
            if (drain_err)  begin err_n++;  err_at = k;  end
            if (s0_ready || s1_ready) rdy_seen = 1'b1;
            if (!busy) begin
                idle_at = k;
                idle_grant = grant;
            end
        end
        ilv_data_valid = 1'b0;

        checks++;
        if (done_n != (ok ? 1 : 0) || err_n != (ok ? 0 : 1)) begin
            errors++;
            $display("FAIL drain_outcome: got done=%0d err=%0d, required done=%0d err=%0d",
                     done_n, err_n, ok ? 1 : 0, ok ? 0 : 1);
        end
        checks++;
        if ((ok ? done_at : err_at) != exit_k + 1) begin
            errors++;
            $display("FAIL drain_timing: got pulse in drain cycle %0d, required %0d",
                     ok ? done_at : err_at, exit_k + 1);
        end
        checks++;
        if (idle_at != exit_k + 2) begin
            errors++;
            $display("FAIL guard_length: got idle in cycle %0d, required %0d", idle_at, exit_k + 2);
        end
        checks++;
        if (rdy_seen || idle_grant !== 2'b00) begin
            errors++;
            $display("FAIL drain_ready_grant: got ready_seen=%b idle_grant=%b, required 0 00",
                     rdy_seen, idle_grant);
        end

        if (ok) frames_ok = (frames_ok + 1) & 16'hFFFF;
        else if (errs_seen < 255) errs_seen++;
`ifdef INTERLEAVER_ARB_STATS_EN
        exp_fcnt = 16'(frames_ok);
        exp_ecnt = 8'(errs_seen);
`else
        exp_fcnt = '0;
        exp_ecnt = '0;
`endif
        checks++;
        if (frame_cnt !== exp_fcnt || err_cnt !== exp_ecnt) begin
            errors++;
            $display("FAIL stats: got frame_cnt=%0d err_cnt=%0d, required %0d %0d",
                     frame_cnt, err_cnt, exp_fcnt, exp_ecnt);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, s0_ready, s1_ready, ilv_load_en, ilv_in_bit, busy,
             frame_done, drain_err, frame_cnt, err_cnt} !== 33'd0) begin
            errors++;
            $display("FAIL reset_state: got grant=%b rdy=%b%b load=%b bit=%b busy=%b done=%b err=%b fcnt=%0d ecnt=%0d, required all 0",
                     grant, s0_ready, s1_ready, ilv_load_en, ilv_in_bit, busy,
                     frame_done, drain_err, frame_cnt, err_cnt);
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || grant !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b grant=%b, required 0 00", busy, grant);
        end
    endtask

    task automatic test_single_frame();
        run_frame(1'b1, 1'b0, -1, 0, 0);
        run_drain(pat_normal(), 1'b0);
    endtask

    task automatic test_round_robin();
        run_frame(1'b1, 1'b1, -1, 0, 0);
        run_drain(pat_normal(), 1'b1);
        run_frame(1'b1, 1'b1, -1, 0, 0);
        run_drain(pat_normal(), 1'b1);
        run_frame(1'b1, 1'b1, -1, 0, 0);
        run_drain(pat_normal(), 1'b0);
    endtask

    task automatic test_stall();
        run_frame(1'b1, 1'b0, 60, 10, 0);
        run_drain(pat_normal(), 1'b0);
    endtask

    task automatic test_timeout();
        run_frame(1'b1, 1'b0, -1, 0, 0);
        run_drain(pat_short(20), 1'b0);
    endtask

    task automatic test_done_on_timeout();
        run_frame(1'b0, 1'b1, -1, 0, 0);
        run_drain(pat_edge(), 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        run_frame(1'b1, 1'b0, -1, 0, 77);
        run_frame(1'b1, 1'b0, -1, 0, 0);
        run_drain(pat_normal(), 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        s0_valid = 1'b0; s0_bit = 1'b0;
        s1_valid = 1'b0; s1_bit = 1'b0;
        ilv_data_valid = 1'b0;
        model_reset();
        test_reset();
        test_single_frame();
        do_reset();
        test_round_robin();
        test_stall();
        test_timeout();
        test_done_on_timeout();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interleaver_arb.md
INTERLEAVER_ARB -- requirements
Module: interleaver_arb

Interface
REQ-001 The block SHALL declare the following parameters (name, default, meaning):
- FRAME_BITS, 128, input bits per interleaver frame.
- FRAME_NIBBLES, 32, interleaved 4-bit outputs expected per frame.
- DRAIN_TIMEOUT, 40, maximum cycles spent in DRAIN.
REQ-002 The block SHALL declare the following ports (name, direction, width, meaning):
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- s0_valid, s1_valid  in  1  requester bit valid.
- s0_bit, s1_bit  in  1  requester serial bit.
- s0_ready, s1_ready  out  1  bit accepted when valid&&ready.
- ilv_load_en  out  1  interleaver load strobe.
- ilv_in_bit  out  1  interleaver input bit.
- ilv_data_valid  in  1  interleaver output-valid pulse.
- grant  out  2  one-hot owner of the current frame.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse on leaving DRAIN normally.
- drain_err  out  1  one-cycle pulse on DRAIN timeout.
- frame_cnt  out  16  completed frames.
- err_cnt  out  8  timeouts, saturating.

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD, DRAIN and GUARD, with the following transitions:
- IDLE->LOAD when any sN_valid is high.
- LOAD->DRAIN on the FRAME_BITS-th accepted bit.
- DRAIN->GUARD on the FRAME_NIBBLES-th ilv_data_valid or on timeout.
- GUARD->IDLE after exactly 1 cycle.
REQ-004 Arbitration SHALL be round-robin per frame, evaluated in IDLE only:
- Single requester wins.
- If both request, the requester not served last wins.
- The pointer after reset favours s0.
REQ-005 grant SHALL be set on the IDLE->LOAD edge and held constant through LOAD, DRAIN and GUARD; it SHALL be cleared on entering IDLE.
REQ-006 sN_ready SHALL equal grant[N] && state==LOAD, combinationally from registered state; a non-granted requester SHALL never see ready.
REQ-007 Each accepted bit SHALL produce ilv_load_en=1 with ilv_in_bit=that bit exactly one cycle later (registered, latency 1); otherwise ilv_load_en=0 and ilv_in_bit holds its last value.
REQ-008 A 7-bit bit counter SHALL count accepted bits, and the LOAD->DRAIN transition SHALL occur on the edge of the 128th acceptance.
REQ-009 Ready SHALL be low from the cycle after that edge, so no 129th bit is accepted.
REQ-010 Loss of valid mid-frame SHALL stall LOAD indefinitely with no timeout; grant SHALL be retained.
REQ-011 DRAIN SHALL count ilv_data_valid pulses (6-bit) and cycles (6-bit), both cleared on entry.
REQ-012 On reaching FRAME_NIBBLES pulses, the block SHALL pulse frame_done and go to GUARD.
REQ-013 On DRAIN_TIMEOUT cycles without reaching FRAME_NIBBLES pulses, the block SHALL pulse drain_err and go to GUARD.
REQ-014 If the count completes and the timeout expires on the same cycle, the block SHALL treat it as success: frame_done only.
REQ-015 ilv_data_valid outside DRAIN SHALL be ignored.
REQ-016 A request arriving in DRAIN or GUARD SHALL wait; arbitration SHALL occur in the first IDLE cycle, giving a minimum of 1 IDLE cycle between frames.
REQ-017 frame_cnt SHALL increment on frame_done and wrap from 0xFFFF to 0.
REQ-018 err_cnt SHALL increment on drain_err and saturate at 0xFF.

Reset
REQ-019 rst high SHALL immediately force:
- state IDLE.
- grant=0, s0_ready=s1_ready=0.
- ilv_load_en=0, ilv_in_bit=0.
- busy=0, frame_done=0, drain_err=0.
- all counters 0.
- round-robin pointer to s0.
REQ-020 Reset mid-frame SHALL discard the partial frame. The interleaver has no reset, so the system SHALL reset it by a full load: 128 bits then drain.

Configuration
REQ-021 Macro INTERLEAVER_ARB_STATS_EN SHALL control the statistics counters:
- Defined: frame_cnt and err_cnt SHALL behave per REQ-017 and REQ-018.
- Undefined: both outputs SHALL be constant 0, with no counter registers synthesized.
- frame_done and drain_err SHALL be unaffected either way.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- s0 only, valid held, 128 bits -> exactly 128 ilv_load_en pulses, each 1 cycle after its transfer, in order.
- Then 32 ilv_data_valid -> frame_done once, frame_cnt=1, GUARD 1 cycle, then IDLE.
- s0 and s1 both valid continuously for 3 frames -> grants s0, s1, s0.
- The non-granted requester's ready SHALL stay 0 throughout.
- s0 drops valid for 10 cycles at bit 60 -> no load_en during the gap, ready stays 1, and the frame completes with 128 bits.
- DRAIN with only 20 ilv_data_valid -> drain_err after 40 cycles, err_cnt=1, frame_done never asserted.
- The 32nd valid on the timeout cycle -> frame_done only.
- rst asserted at bit 77 -> all outputs 0 within the same cycle.
- After release, next frame from s0 loads 128 bits from count 0.
- frame_cnt SHALL be 0 without INTERLEAVER_ARB_STATS_EN.
